// File: rtl/stbuf_pkg.sv
// Shared types and constants for the store buffer.
package stbuf_pkg;

  localparam int unsigned LineAddrWidth   = 26;
  localparam int unsigned LineBytes       = 64;
  localparam int unsigned LineBits        = LineBytes * 8;
  localparam int unsigned DefaultDepth    = 4;
  localparam int unsigned DefaultPtrWidth = $clog2(DefaultDepth);

  typedef struct packed {
    logic                     valid;
    logic [LineAddrWidth-1:0] addr;
    logic [LineBytes-1:0]     mask;
    logic [LineBits-1:0]      data;
  } stbuf_entry_t;

  // Pointer width for a given depth; never narrower than one bit.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stbuf_merge.sv
// Byte-masked merge of a new store into an existing line.
// Mask bit n selects byte data[LineBits-1-8n -: 8].
module stbuf_merge
  import stbuf_pkg::*;
(
  input  logic [LineBits-1:0]  old_data_i,
  input  logic [LineBytes-1:0] old_mask_i,
  input  logic [LineBits-1:0]  new_data_i,
  input  logic [LineBytes-1:0] new_mask_i,
  output logic [LineBits-1:0]  merged_data_o,
  output logic [LineBytes-1:0] merged_mask_o
);

  // Replace each byte enabled by the new mask; keep the rest.
  always_comb begin
    merged_data_o = old_data_i;
    for (int n = 0; n < int'(LineBytes); n++) begin
      if (new_mask_i[n]) begin
        merged_data_o[int'(LineBits) - 1 - 8 * n -: 8] = new_data_i[int'(LineBits) - 1 - 8 * n -: 8];
      end
    end
  end

  assign merged_mask_o = old_mask_i | new_mask_i;

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer: circular FIFO of full-line masked stores drained to L2.
// Define STBUF_COMBINE_EN to compile in write combining into non-head entries.
module store_buffer
  import stbuf_pkg::*;
#(
  parameter int unsigned DEPTH           = DefaultDepth,
  parameter int unsigned LINE_ADDR_WIDTH = LineAddrWidth
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       dwrite_i,
  input  logic [31:0]                daddress_i,
  input  logic [63:0]                dwrite_mask_i,
  input  logic [511:0]               ddata_i,
  output logic                       dstbuf_full_o,
  output logic                       l2_write_o,
  output logic [LINE_ADDR_WIDTH-1:0] l2_address_o,
  output logic [63:0]                l2_mask_o,
  output logic [511:0]               l2_data_o,
  input  logic                       l2_ack_i
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  stbuf_entry_t            entries_q [DEPTH];
  stbuf_entry_t            entries_d [DEPTH];
  logic [PtrW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    full_q, full_d;

  logic [LineAddrWidth-1:0] new_addr;
  logic                     accept, pop, hit;
  stbuf_entry_t             head_entry;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^daddress_i[5:0];

  assign new_addr   = daddress_i[31:6];
  assign accept     = dwrite_i && !full_q;
  assign pop        = l2_ack_i && (count_q != '0);
  assign head_entry = entries_q[head_q];

`ifdef STBUF_COMBINE_EN
  logic [PtrW-1:0]      hit_idx;
  logic [LineBits-1:0]  merged_data;
  logic [LineBytes-1:0] merged_mask;

  // Find the unique valid non-head entry holding the same line.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entries_q[i].valid && (PtrW'(i) != head_q) && (entries_q[i].addr == new_addr)) begin
        hit     = 1'b1;
        hit_idx = PtrW'(i);
      end
    end
  end

  stbuf_merge u_merge (
    .old_data_i    (entries_q[hit_idx].data),
    .old_mask_i    (entries_q[hit_idx].mask),
    .new_data_i    (ddata_i),
    .new_mask_i    (dwrite_mask_i),
    .merged_data_o (merged_data),
    .merged_mask_o (merged_mask)
  );
`else
  assign hit = 1'b0;
`endif

  // Next-state: drain the head on ack, then allocate or merge the accepted store.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + 1'b1;
    end

    if (accept) begin
`ifdef STBUF_COMBINE_EN
      if (hit) begin
        entries_d[hit_idx].data = merged_data;
        entries_d[hit_idx].mask = merged_mask;
      end
`endif
      if (!hit) begin
        entries_d[tail_q] = '{valid: 1'b1, addr: new_addr, mask: dwrite_mask_i, data: ddata_i};
        tail_d            = tail_q + 1'b1;
      end
    end

    if ((accept && !hit) && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!(accept && !hit) && pop) begin
      count_d = count_q - 1'b1;
    end

    full_d = (count_d == FullCnt);
  end

  // State registers; reset discards every queued store at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entries_q <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      full_q    <= full_d;
    end
  end

  // Present the head entry; fields read as zero while empty.
  always_comb begin
    dstbuf_full_o = full_q;
    l2_write_o    = (count_q != '0);
    l2_address_o  = '0;
    l2_mask_o     = '0;
    l2_data_o     = '0;
    if (l2_write_o) begin
      l2_address_o = LINE_ADDR_WIDTH'(head_entry.addr);
      l2_mask_o    = head_entry.mask;
      l2_data_o    = head_entry.data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
module tb_store_buffer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         dwrite_i;
  logic [31:0]  daddress_i;
  logic [63:0]  dwrite_mask_i;
  logic [511:0] ddata_i;
  logic         dstbuf_full_o;
  logic         l2_write_o;
  logic [25:0]  l2_address_o;
  logic [63:0]  l2_mask_o;
  logic [511:0] l2_data_o;
  logic         l2_ack_i;

  int errors = 0;
  int checks = 0;

  store_buffer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dwrite_i      (dwrite_i),
    .daddress_i    (daddress_i),
    .dwrite_mask_i (dwrite_mask_i),
    .ddata_i       (ddata_i),
    .dstbuf_full_o (dstbuf_full_o),
    .l2_write_o    (l2_write_o),
    .l2_address_o  (l2_address_o),
    .l2_mask_o     (l2_mask_o),
    .l2_data_o     (l2_data_o),
    .l2_ack_i      (l2_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int k);
    return {16{32'hA500_0000 + 32'(k)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one store (optionally with an ack) for exactly one edge.
  task automatic store(input logic [25:0] line, input logic [63:0] mask, input logic [511:0] data,
                       input logic ack);
    dwrite_i      = 1'b1;
    daddress_i    = {line, 6'h15};
    dwrite_mask_i = mask;
    ddata_i       = data;
    l2_ack_i      = ack;
    tick();
    dwrite_i = 1'b0;
    l2_ack_i = 1'b0;
  endtask

  // Check the head line, then ack it.
  task automatic drain(input string tag, input logic [25:0] line);
    check({tag, ".valid"}, 512'(l2_write_o), 512'(1'b1));
    check({tag, ".addr"}, 512'(l2_address_o), 512'(line));
    l2_ack_i = 1'b1;
    tick();
    l2_ack_i = 1'b0;
  endtask

  logic [511:0] exp_data;

  initial begin
    reset_n = 1'b0; dwrite_i = 1'b0; daddress_i = '0; dwrite_mask_i = '0; ddata_i = '0;
    l2_ack_i = 1'b0;
    #3;
    check("rst.write", 512'(l2_write_o), 512'(0));
    check("rst.full", 512'(dstbuf_full_o), 512'(0));
    check("rst.addr", 512'(l2_address_o), 512'(0));
    check("rst.mask", 512'(l2_mask_o), 512'(0));
    check("rst.data", l2_data_o, 512'(0));
    #19 reset_n = 1'b1;
    tick();

    // Single store, held until acked.
    dwrite_i = 1'b1; daddress_i = 32'h0000_1040; dwrite_mask_i = '1; ddata_i = pat(1);
    tick();
    dwrite_i = 1'b0;
    check("single.write", 512'(l2_write_o), 512'(1));
    check("single.addr", 512'(l2_address_o), 512'(26'h41));
    check("single.mask", 512'(l2_mask_o), 512'({64{1'b1}}));
    check("single.data", l2_data_o, pat(1));
    tick(); tick();
    check("single.hold_addr", 512'(l2_address_o), 512'(26'h41));
    check("single.hold_data", l2_data_o, pat(1));
    l2_ack_i = 1'b1; tick(); l2_ack_i = 1'b0;
    check("single.done", 512'(l2_write_o), 512'(0));
    l2_ack_i = 1'b1; tick(); l2_ack_i = 1'b0;
    check("single.ack_empty", 512'(l2_write_o), 512'(0));

    // Fill to full, drop while full (also with a same-cycle ack), retry.
    store(26'h10, '1, pat(16), 1'b0);
    store(26'h11, '1, pat(17), 1'b0);
    store(26'h12, '1, pat(18), 1'b0);
    check("fill.not_full3", 512'(dstbuf_full_o), 512'(0));
    store(26'h13, '1, pat(19), 1'b0);
    check("fill.full", 512'(dstbuf_full_o), 512'(1));
    store(26'h14, '1, pat(20), 1'b0);
    check("fill.drop_full", 512'(dstbuf_full_o), 512'(1));
    check("fill.head", 512'(l2_address_o), 512'(26'h10));
    store(26'h14, '1, pat(20), 1'b1);
    check("fill.full_clear", 512'(dstbuf_full_o), 512'(0));
    check("fill.head_after_ack", 512'(l2_address_o), 512'(26'h11));
    store(26'h14, '1, pat(20), 1'b0);
    check("fill.refull", 512'(dstbuf_full_o), 512'(1));
    drain("fill.d1", 26'h11);
    check("fill.unfull", 512'(dstbuf_full_o), 512'(0));
    drain("fill.d2", 26'h12);
    drain("fill.d3", 26'h13);
    check("fill.d4_data", l2_data_o, pat(20));
    drain("fill.d4", 26'h14);
    check("fill.empty", 512'(l2_write_o), 512'(0));

    // Simultaneous accept and ack at count 2.
    store(26'h50, '1, pat(80), 1'b0);
    store(26'h51, '1, pat(81), 1'b0);
    store(26'h52, '1, pat(82), 1'b1);
    drain("simul.d1", 26'h51);
    drain("simul.d2", 26'h52);
    check("simul.empty", 512'(l2_write_o), 512'(0));

    // Combining into a non-head entry.
    store(26'h20, 64'h0F, pat(2), 1'b0);
    store(26'h30, 64'h0F, pat(3), 1'b0);
    store(26'h30, 64'hF0, pat(4), 1'b0);
    drain("comb.d1", 26'h20);
`ifdef STBUF_COMBINE_EN
    exp_data = pat(3);
    exp_data[479:448] = 32'hA500_0004;
    check("comb.mask", 512'(l2_mask_o), 512'(64'hFF));
    check("comb.data", l2_data_o, exp_data);
    drain("comb.d2", 26'h30);
`else
    check("comb.mask_a", 512'(l2_mask_o), 512'(64'h0F));
    check("comb.data_a", l2_data_o, pat(3));
    drain("comb.d2", 26'h30);
    check("comb.mask_b", 512'(l2_mask_o), 512'(64'hF0));
    check("comb.data_b", l2_data_o, pat(4));
    drain("comb.d3", 26'h30);
`endif
    check("comb.empty", 512'(l2_write_o), 512'(0));

    // Head is never a combine target.
    store(26'h20, 64'h01, pat(5), 1'b0);
    store(26'h20, 64'h02, pat(6), 1'b0);
    check("headx.mask1", 512'(l2_mask_o), 512'(64'h01));
    drain("headx.d1", 26'h20);
    check("headx.mask2", 512'(l2_mask_o), 512'(64'h02));
    check("headx.data2", l2_data_o, pat(6));
    drain("headx.d2", 26'h20);
    check("headx.empty", 512'(l2_write_o), 512'(0));

    // Asynchronous reset with three entries queued.
    store(26'h60, '1, pat(96), 1'b0);
    store(26'h61, '1, pat(97), 1'b0);
    store(26'h62, '1, pat(98), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid.write", 512'(l2_write_o), 512'(0));
    check("rstmid.full", 512'(dstbuf_full_o), 512'(0));
    check("rstmid.addr", 512'(l2_address_o), 512'(0));
    #2 reset_n = 1'b1;
    tick();
    store(26'h77, '1, pat(7), 1'b0);
    check("rstmid.new_data", l2_data_o, pat(7));
    drain("rstmid.d1", 26'h77);
    check("rstmid.empty", 512'(l2_write_o), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
